// File: rtl/period_to_freq_pkg.sv
// Shared types and constants for the period-to-frequency converter.
package period_to_freq_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  localparam int          DIV_W   = 36;
  localparam int          AVG_N   = 4;
  localparam logic [31:0] SAT_VAL = 32'hFFFF_FFFF;

  // Clamp a wide quotient into the 32-bit frequency result.
  function automatic logic [31:0] saturate(input logic [DIV_W-1:0] q);
    return (|q[DIV_W-1:32]) ? SAT_VAL : q[31:0];
  endfunction

endpackage

// File: rtl/period_to_freq_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done is high in the 36th step,
// with quotient already holding the final result (start is ignored only by being unused while running).
module seq_divider
  import period_to_freq_pkg::*;
(
  input  logic             sys_count_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic             run;
  logic [5:0]       cnt;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvd;
  logic [DIV_W-1:0] dsr;
  logic [DIV_W:0]   rem_sh;
  logic             q_bit;
  logic [DIV_W-1:0] rem_nxt;

  // dvd doubles as the quotient register: dividend bits shift out, quotient bits shift in.
  assign rem_sh   = {rem, dvd[DIV_W-1]};
  assign q_bit    = (rem_sh >= {1'b0, dsr});
  assign rem_nxt  = q_bit ? DIV_W'(rem_sh - {1'b0, dsr}) : rem_sh[DIV_W-1:0];
  assign done     = run && (cnt == 6'(DIV_W - 1));
  assign quotient = {dvd[DIV_W-2:0], q_bit};

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= '0;
      dvd <= dividend;
      dsr <= divisor;
    end else if (run) begin
      rem <= rem_nxt;
      dvd <= quotient;
      cnt <= cnt + 6'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/period_to_freq.sv
// Converts a period in sys_count_clk cycles to Hz; result 37 cycles after acceptance, strobes arriving
// while busy are dropped with an overrun pulse. PERIOD_AVG_EN averages 4 periods before dividing.
module period_to_freq
  import period_to_freq_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        sys_count_clk,
  input  logic        rst_n,
  input  logic [31:0] period_in,
  input  logic        period_valid,
  output logic [31:0] freq_out,
  output logic        freq_valid,
  output logic        busy,
  output logic        div_zero,
  output logic        overrun
);

  state_t           state, state_nxt;
  logic             div_start;
  logic             div_done;
  logic             zero_hit;
  logic [DIV_W-1:0] div_dsr;
  logic [DIV_W-1:0] div_q;

`ifdef PERIOD_AVG_EN
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ) * DIV_W'(AVG_N);
  logic [33:0] acc;
  logic [33:0] sum;
  logic [1:0]  acc_cnt;
  logic        acc_load;
  logic        acc_add;

  assign sum     = acc + 34'(period_in);
  assign div_dsr = DIV_W'(sum);
`else
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
  assign div_dsr = DIV_W'(period_in);
`endif

  assign busy    = (state == DIVIDE) || (state == DONE);
  assign overrun = period_valid && busy;

  seq_divider u_div (
    .sys_count_clk (sys_count_clk),
    .rst_n         (rst_n),
    .start         (div_start),
    .dividend      (DIVIDEND),
    .divisor       (div_dsr),
    .done          (div_done),
    .quotient      (div_q)
  );

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    zero_hit  = 1'b0;
`ifdef PERIOD_AVG_EN
    acc_load  = 1'b0;
    acc_add   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (period_valid) begin
`ifdef PERIOD_AVG_EN
          acc_load  = 1'b1;
          state_nxt = ACCUM;
`else
          if (div_dsr == '0) begin
            zero_hit = 1'b1;
          end else begin
            div_start = 1'b1;
            state_nxt = DIVIDE;
          end
`endif
        end
      end
`ifdef PERIOD_AVG_EN
      ACCUM: begin
        if (period_valid) begin
          if (acc_cnt == 2'(AVG_N - 1)) begin
            if (div_dsr == '0) begin
              zero_hit  = 1'b1;
              state_nxt = IDLE;
            end else begin
              div_start = 1'b1;
              state_nxt = DIVIDE;
            end
          end else begin
            acc_add = 1'b1;
          end
        end
      end
`endif
      DIVIDE:  if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      div_zero   <= 1'b0;
      if (zero_hit) begin
        freq_out   <= SAT_VAL;
        freq_valid <= 1'b1;
        div_zero   <= 1'b1;
      end else if (state == DIVIDE && div_done) begin
        freq_out   <= saturate(div_q);
        freq_valid <= 1'b1;
      end
    end
  end

`ifdef PERIOD_AVG_EN
  always_ff @(posedge sys_count_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (acc_load) begin
      acc     <= 34'(period_in);
      acc_cnt <= 2'd1;
    end else if (acc_add) begin
      acc     <= sum;
      acc_cnt <= acc_cnt + 2'd1;
    end else if (state != ACCUM) begin
      acc     <= '0;
      acc_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_period_to_freq.sv
// Directed bench for period_to_freq: vector table for single divisions plus overrun/reset sequences.
module tb_period_to_freq;

  logic        sys_count_clk = 1'b0;
  logic        rst_n;
  logic [31:0] period_in;
  logic        period_valid;
  logic [31:0] freq_out;
  logic        freq_valid;
  logic        busy;
  logic        div_zero;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;

  period_to_freq #(.CLK_HZ(50_000_000)) dut (
    .sys_count_clk (sys_count_clk),
    .rst_n         (rst_n),
    .period_in     (period_in),
    .period_valid  (period_valid),
    .freq_out      (freq_out),
    .freq_valid    (freq_valid),
    .busy          (busy),
    .div_zero      (div_zero),
    .overrun       (overrun)
  );

  always #5 sys_count_clk = ~sys_count_clk;

  typedef struct {
    logic [31:0] period;
    logic [31:0] freq;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Strobe for one cycle (cycle T); returns at the negedge of cycle T+1.
  task automatic strobe(input logic [31:0] p);
    @(negedge sys_count_clk);
    period_in    = p;
    period_valid = 1'b1;
    @(negedge sys_count_clk);
    period_valid = 1'b0;
  endtask

  // Starting at cycle T+start_lat, wait (bounded) for freq_valid; lat is the cycle offset from T.
  task automatic wait_result(input int start_lat, output int lat, output int busy_low);
    lat      = start_lat;
    busy_low = 0;
    while (!freq_valid && lat < 80) begin
      if (!busy) busy_low++;
      @(negedge sys_count_clk);
      lat++;
    end
    if (!busy) busy_low++;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_count_clk);
      if (freq_valid) n++;
    end
  endtask

  vec_t vecs[10];
  int   lat, bl, nv;

  initial begin
    rst_n        = 1'b0;
    period_in    = '0;
    period_valid = 1'b1;
    #1;
    check("reset freq_out", freq_out, 32'd0);
    check("reset freq_valid", 32'(freq_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    period_valid = 1'b0;
    repeat (3) @(negedge sys_count_clk);
    rst_n = 1'b1;
    @(negedge sys_count_clk);

`ifdef PERIOD_AVG_EN
    strobe(32'd50000);
    check("accum busy low", 32'(busy), 32'd0);
    strobe(32'd50000);
    strobe(32'd50001);
    check("accum no result", 32'(freq_valid), 32'd0);
    strobe(32'd49999);
    wait_result(1, lat, bl);
    check("avg latency", 32'(lat), 32'd37);
    check("avg freq", freq_out, 32'd1000);
    check("avg busy during divide", 32'(bl), 32'd0);
    count_valid(40, nv);
    check("avg single result", 32'(nv), 32'd0);
    strobe(32'd0); strobe(32'd0); strobe(32'd0); strobe(32'd0);
    check("avg zero freq", freq_out, 32'hFFFF_FFFF);
    check("avg zero div_zero", 32'(div_zero), 32'd1);
    check("avg zero valid", 32'(freq_valid), 32'd1);
`else
    vecs[0] = '{32'd50000,      32'd1000,        1'b0, 37};
    vecs[1] = '{32'd3,          32'd16666666,    1'b0, 37};
    vecs[2] = '{32'd1,          32'd50000000,    1'b0, 37};
    vecs[3] = '{32'd0,          32'hFFFF_FFFF,   1'b1, 1};
    vecs[4] = '{32'd25000,      32'd2000,        1'b0, 37};
    vecs[5] = '{32'd7,          32'd7142857,     1'b0, 37};
    vecs[6] = '{32'hFFFF_FFFF,  32'd0,           1'b0, 37};
    vecs[7] = '{32'd50000001,   32'd0,           1'b0, 37};
    vecs[8] = '{32'd49999999,   32'd1,           1'b0, 37};
    vecs[9] = '{32'd0,          32'hFFFF_FFFF,   1'b1, 1};

    for (int i = 0; i < 10; i++) begin
      strobe(vecs[i].period);
      check($sformatf("v%0d busy T+1", i), 32'(busy), 32'(vecs[i].dz == 1'b0));
      wait_result(1, lat, bl);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d freq", i), freq_out, vecs[i].freq);
      check($sformatf("v%0d div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
      if (!vecs[i].dz) check($sformatf("v%0d busy low cycles", i), 32'(bl), 32'd0);
      @(negedge sys_count_clk);
      check($sformatf("v%0d valid one cycle", i), 32'(freq_valid), 32'd0);
      check($sformatf("v%0d idle after", i), 32'(busy), 32'd0);
      check($sformatf("v%0d freq held", i), freq_out, vecs[i].freq);
      @(negedge sys_count_clk);
    end

    // Overrun: second strobe at T+5 dropped, first division completes unaffected.
    strobe(32'd50000);
    repeat (4) @(negedge sys_count_clk);
    period_in    = 32'd10;
    period_valid = 1'b1;
    #1;
    check("overrun pulse", 32'(overrun), 32'd1);
    @(negedge sys_count_clk);
    period_valid = 1'b0;
    #1;
    check("overrun single cycle", 32'(overrun), 32'd0);
    wait_result(6, lat, bl);
    check("overrun latency", 32'(lat), 32'd37);
    check("overrun freq", freq_out, 32'd1000);
    count_valid(50, nv);
    check("overrun no second result", 32'(nv), 32'd0);

    // Strobe landing in the DONE cycle is also an overrun.
    strobe(32'd50000);
    wait_result(1, lat, bl);
    period_in    = 32'd10;
    period_valid = 1'b1;
    #1;
    check("overrun in DONE", 32'(overrun), 32'd1);
    @(negedge sys_count_clk);
    period_valid = 1'b0;
    count_valid(50, nv);
    check("DONE strobe dropped", 32'(nv), 32'd0);

    // Reset mid-division aborts it; next strobe works normally.
    strobe(32'd50000);
    repeat (19) @(negedge sys_count_clk);
    rst_n = 1'b0;
    #1;
    check("midreset freq_out", freq_out, 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge sys_count_clk);
    rst_n = 1'b1;
    count_valid(40, nv);
    check("midreset no result", 32'(nv), 32'd0);
    check("midreset freq held 0", freq_out, 32'd0);
    strobe(32'd25000);
    wait_result(1, lat, bl);
    check("post-reset latency", 32'(lat), 32'd37);
    check("post-reset freq", freq_out, 32'd2000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/period_to_freq.md
PERIOD_TO_FREQ -- requirements
Module: period_to_freq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: measurement clock frequency in Hz (the dividend), 1..2^30-1.
REQ-002 SHALL have port sys_count_clk  in  1  measurement clock; all logic rising-edge on it.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port period_in  in  32  period of the input signal, in sys_count_clk cycles.
REQ-005 SHALL have port period_valid  in  1  single-cycle strobe; period_in is valid in that cycle.
REQ-006 SHALL have port freq_out  out  32  computed frequency in Hz, held until the next result.
REQ-007 SHALL have port freq_valid  out  1  single-cycle strobe in the cycle freq_out updates.
REQ-008 SHALL have port busy  out  1  high while a division is in progress.
REQ-009 SHALL have port div_zero  out  1  single-cycle strobe, coincident with freq_valid, when the divisor was 0.
REQ-010 SHALL have port overrun  out  1  single-cycle strobe when period_valid arrives while busy.

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, DIVIDE, DONE; DIVIDE and DONE both assert busy.
REQ-012 In IDLE, period_valid SHALL latch the divisor and go to DIVIDE (or to ACCUM under REQ-024).
REQ-013 DIVIDE SHALL run a restoring division with 36-bit dividend and divisor, one quotient bit per cycle, MSB first, for exactly 36 cycles.
REQ-014 Latency: if accepted at cycle T, freq_valid and freq_out SHALL update at T+37, with the FSM back in IDLE at T+38.
REQ-015 Quotient SHALL truncate (floor); a quotient above 32'hFFFF_FFFF SHALL saturate to 32'hFFFF_FFFF.
REQ-016 Divisor 0 SHALL skip DIVIDE, give freq_out=32'hFFFF_FFFF with freq_valid and div_zero at T+1, then return to IDLE.
REQ-017 period_valid while busy SHALL be dropped and pulse overrun in the same cycle; the running division is unaffected.
REQ-018 period_valid in the DONE cycle counts as busy (REQ-017).
REQ-019 freq_out SHALL hold its value between results; freq_valid, div_zero and overrun SHALL never be high for more than one cycle.

Reset
REQ-020 rst_n low SHALL immediately force: FSM to IDLE, freq_out=0, freq_valid=0, busy=0, div_zero=0, overrun=0, and clear the accumulator and sample count.
REQ-021 Reset during DIVIDE or ACCUM SHALL abort the operation and produce no freq_valid.
REQ-022 After rst_n deasserts, the first period_valid SHALL be accepted normally.

Configuration
REQ-023 Macro PERIOD_AVG_EN SHALL select averaging.
REQ-024 With PERIOD_AVG_EN defined:
- ACCUM sums 4 accepted periods into a 34-bit accumulator; busy stays low in ACCUM.
- The 4th strobe moves to DIVIDE with dividend CLK_HZ*4 and divisor = sum.
- Latency (REQ-014) counts from the 4th strobe.
- A zero sum triggers REQ-016.
REQ-025 Without PERIOD_AVG_EN, ACCUM, the accumulator and the sample counter SHALL not exist; each strobe divides CLK_HZ by period_in.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, DIV_W=36, AVG_N=4, and the saturation constant 32'hFFFF_FFFF.
REQ-027 The shift-subtract datapath SHALL be a sub-module seq_divider (start, dividend, divisor, done, quotient); period_to_freq holds the FSM, averaging, saturation and flags.

Verification
REQ-028 period_in=50000 strobed at T -> freq_out=1000, freq_valid at T+37, busy high T+1..T+37.
REQ-029 period_in=3 -> freq_out=16666666 (truncated); period_in=1 -> 50000000.
REQ-030 period_in=0 -> freq_out=32'hFFFF_FFFF, with freq_valid and div_zero at T+1.
REQ-031 Strobe 50000 at T, then strobe 10 at T+5 -> overrun at T+5, freq_out=1000 at T+37, no second result.
REQ-032 rst_n low at T+20 of a division -> freq_out=0, no freq_valid; the next strobe of 25000 -> 2000.
REQ-033 With PERIOD_AVG_EN, strobes 50000, 50000, 50001, 49999 -> a single freq_out=1000, 37 cycles after the 4th strobe.
